// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: 2-flop sync, per-channel debounce, polarity
// normalisation, press/release pulses and optional auto-repeat. release/repeat are SV keywords, hence *_pulse.
module debounce_bank #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned INTERVAL     = 1000000,
  parameter int unsigned CNT_W        = 21,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned REPEAT_DELAY = 0,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned RPT_W        = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  localparam logic [CHANNELS-1:0] IDLE    = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(INTERVAL);

  logic [CHANNELS-1:0] s1, s2, raw, sample, levelNext, rise, fall;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  always_comb begin
    raw       = s2 ^ IDLE;
    levelNext = level;
    // A saturated count commits even on the edge a new value arrives, so INTERVAL+1 stable samples suffice
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cnt[i] == CNT_MAX) levelNext[i] = sample[i];
    end
    rise = levelNext & ~level;
    fall = level & ~levelNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= IDLE;
      s2            <= IDLE;
      sample        <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      s1            <= btn_in;
      s2            <= s1;
      level         <= levelNext;
      press         <= rise;
      release_pulse <= fall;
      any_press     <= |rise;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (raw[i] != sample[i]) begin
          sample[i] <= raw[i];
          cnt[i]    <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  if (REPEAT_DELAY != 0) begin : gRepeat
    localparam logic [RPT_W-1:0] DLY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RATE = RPT_W'(REPEAT_RATE);

    logic [RPT_W-1:0]    hold    [CHANNELS];
    logic [RPT_W-1:0]    holdInc [CHANNELS];
    logic [CHANNELS-1:0] phaseRate, hit;

    // hold is zero-based: a pulse fires on the edge where the incremented count meets the target
    always_comb begin
      hit = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        holdInc[i] = hold[i] + RPT_W'(1);
        hit[i]     = (holdInc[i] == (phaseRate[i] ? RATE : DLY));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        repeat_pulse <= '0;
        phaseRate    <= '0;
        for (int unsigned i = 0; i < CHANNELS; i++) hold[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (!levelNext[i] || rise[i]) begin
            hold[i]         <= '0;
            phaseRate[i]    <= 1'b0;
            repeat_pulse[i] <= 1'b0;
          end else if (hit[i]) begin
            hold[i]         <= '0;
            phaseRate[i]    <= 1'b1;
            repeat_pulse[i] <= 1'b1;
          end else begin
            hold[i]         <= holdInc[i];
            repeat_pulse[i] <= 1'b0;
          end
        end
      end
    end
  end else begin : gNoRepeat
    assign repeat_pulse = '0;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised self-checking bench for debounce_bank against an edge-indexed pad-history model.
module tb_debounce_bank;
  localparam int unsigned CH = 4;
  localparam int          IV = 8;
  localparam int          RD = 20;
  localparam int          RR = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn_in = 4'hF;
  logic [CH-1:0] level, press, release_pulse, repeat_pulse;
  logic          any_press;

  int nChecks = 0;
  int nFails  = 0;

  debounce_bank #(
    .CHANNELS(CH), .INTERVAL(IV), .CNT_W(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level), .press(press),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Model: level takes value v once the pressed state of the pad was v on the INTERVAL+1
  // consecutive samples taken 3..3+INTERVAL edges ago; repeats follow P+RD+k*RR.
  logic [CH-1:0] hist [$];
  int            e = 0;
  int            pressAt [CH];
  logic [CH-1:0] mLevel = '0, mPress = '0, mRel = '0, mRpt = '0;
  logic          mAny = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [CH-1:0] nl;
    logic          v0, vk, same;
    int            n, d;
    if (!rst_n) begin
      hist.delete();
      e = 0;
      mLevel = '0; mPress = '0; mRel = '0; mRpt = '0; mAny = 1'b0;
    end else begin
      hist.push_back(btn_in);
      nl = mLevel;
      for (int c = 0; c < CH; c++) begin
        same = 1'b1;
        n = e - 3;
        v0 = (n < 0) ? 1'b0 : ~hist[n][c];
        for (int k = 4; k <= 3 + IV; k++) begin
          n = e - k;
          vk = (n < 0) ? 1'b0 : ~hist[n][c];
          if (vk != v0) same = 1'b0;
        end
        if (same) nl[c] = v0;
      end
      mPress = nl & ~mLevel;
      mRel   = mLevel & ~nl;
      mAny   = |mPress;
      for (int c = 0; c < CH; c++) begin
        if (mPress[c]) pressAt[c] = e;
        d = e - pressAt[c];
        mRpt[c] = nl[c] && !mPress[c] && (d >= RD) && (((d - RD) % RR) == 0);
      end
      mLevel = nl;
      e++;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkVal("level",    32'(level),         32'(mLevel));
    checkVal("press",    32'(press),         32'(mPress));
    checkVal("release",  32'(release_pulse), 32'(mRel));
    checkVal("repeat",   32'(repeat_pulse),  32'(mRpt));
    checkVal("anyPress", 32'(any_press),     32'(mAny));
  endtask

  task automatic step();
    @(negedge clk);
    checkAll();
  endtask

  int waited, cntA, cntB, t0, t1, firstR, secondR;
  logic found;

  initial begin
    // reset and idle
    repeat (3) step();
    checkVal("rstLevel", 32'(level), 32'd0);
    rst_n = 1'b1;
    repeat (30) step();
    checkVal("idleLevel", 32'(level), 32'd0);

    // single press latency on ch0
    btn_in[0] = 1'b0;
    found = 1'b0; waited = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step();
      if (level[0]) begin found = 1'b1; waited = i; end
    end
    checkVal("lat0", 32'(waited), 32'd12);
    checkVal("press0", 32'(press), 32'h1);
    repeat (5) step();
    btn_in[0] = 1'b1;
    repeat (20) step();

    // bounce on ch1
    cntA = 0;
    for (int i = 0; i < 20; i++) begin
      btn_in[1] = ~btn_in[1];
      repeat (3) begin step(); if (press[1]) cntA++; end
    end
    checkVal("bounceNoPress", 32'(cntA), 32'd0);
    btn_in[1] = 1'b0;
    found = 1'b0; waited = 0; cntB = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (press[1]) begin cntB++; if (!found) waited = i; found = 1'b1; end
    end
    checkVal("bounceLat", 32'(waited), 32'd12);
    checkVal("bounceOnce", 32'(cntB), 32'd1);
    btn_in[1] = 1'b1;
    repeat (20) step();

    // glitches on ch2: 8 rejected, 9 accepted
    btn_in[2] = 1'b0;
    repeat (8) step();
    btn_in[2] = 1'b1;
    cntA = 0;
    repeat (25) begin step(); if (press[2] || release_pulse[2]) cntA++; end
    checkVal("glitch8", 32'(cntA), 32'd0);
    btn_in[2] = 1'b0;
    repeat (9) step();
    btn_in[2] = 1'b1;
    t0 = -1; t1 = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (press[2]) t0 = i;
      if (release_pulse[2]) t1 = i;
    end
    checkVal("glitch9Press", 32'(t0 >= 0), 32'd1);
    checkVal("glitch9Gap", 32'(t1 - t0), 32'd9);

    // auto-repeat on ch3
    btn_in[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = press[3]; end
    checkVal("press3Seen", 32'(found), 32'd1);
    firstR = -1; secondR = -1; cntA = 0;
    for (int k = 1; k <= 59; k++) begin
      step();
      if (repeat_pulse[3]) begin
        cntA++;
        if (firstR < 0) firstR = k; else if (secondR < 0) secondR = k;
      end
    end
    checkVal("rptFirst", 32'(firstR), 32'd20);
    checkVal("rptSecond", 32'(secondR), 32'd25);
    checkVal("rptCount", 32'(cntA), 32'd8);
    btn_in[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = release_pulse[3]; end
    checkVal("rel3Seen", 32'(found), 32'd1);
    cntA = 0;
    repeat (20) begin step(); if (repeat_pulse[3]) cntA++; end
    checkVal("rptAfterRel", 32'(cntA), 32'd0);

    // simultaneous press, then reset mid-hold
    btn_in = 4'b0110;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = press[0]; end
    checkVal("dualPress", 32'(press), 32'h9);
    checkVal("dualAny", 32'(any_press), 32'd1);
    repeat (30) step();
    #2 rst_n = 1'b0;
    #1;
    checkVal("rstMidLevel", 32'(level), 32'd0);
    checkVal("rstMidRpt", 32'(repeat_pulse), 32'd0);
    checkAll();
    btn_in = 4'hF;
    repeat (3) step();
    rst_n = 1'b1;
    cntA = 0;
    repeat (20) begin step(); if (release_pulse != 0) cntA++; end
    checkVal("noRelAfterRst", 32'(cntA), 32'd0);

    // random pad activity
    for (int s = 0; s < 60; s++) begin
      btn_in = 4'($urandom);
      repeat ($urandom_range(1, 14)) step();
    end
    btn_in = 4'hF;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
